// File: rtl/ranging_pkg.sv
// ============================================================================
// Module   : ranging_pkg
// Brief    : Shared types and constants for the ultrasonic ranging front-end.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ranging_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int US_DIV         = CLK_HZ_DEFAULT / 1_000_000;
    localparam int DIST_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    // Clocks per microsecond for an arbitrary system clock.
    function automatic int us_div(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/us_tick_gen.sv
// ============================================================================
// Module   : us_tick_gen
// Brief    : Prescaler producing a one-cycle tick every DIV clocks, with a
//            synchronous clear that restarts the period.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module us_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear arriving on a tick cycle still lets that tick through: it
    // belongs to the state being left.
    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/ultrasonic_echo_timer.sv
// ============================================================================
// Module   : ultrasonic_echo_timer
// Brief    : Fires a trigger pulse, times the synchronised echo high period in
//            microseconds and converts it on the fly to whole centimetres.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ultrasonic_echo_timer
    import ranging_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TRIG_US    = 10,
    parameter int CM_US      = 58,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout
);

    localparam int c_us_div  = us_div(CLK_HZ);
    localparam int c_max_a   = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
    localparam int c_max_us  = (c_max_a > HOLDOFF_US) ? c_max_a : HOLDOFF_US;
    localparam int c_us_w    = $clog2(c_max_us + 1);
    localparam int c_sub_w   = (CM_US > 1) ? $clog2(CM_US) : 1;

    localparam logic [c_us_w-1:0]  c_trig_last = c_us_w'(TRIG_US - 1);
    localparam logic [c_us_w-1:0]  c_to_last   = c_us_w'(TIMEOUT_US - 1);
    localparam logic [c_us_w-1:0]  c_hold_last = c_us_w'(HOLDOFF_US - 1);
    localparam logic [c_sub_w-1:0] c_sub_last  = c_sub_w'(CM_US - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_state_chg;

    logic                r_start_d;
    logic                r_echo_s1;
    logic                r_echo_s2;
    logic                r_echo_d;

    logic [c_us_w-1:0]   r_us_cnt;
    logic [c_sub_w-1:0]  r_sub_cnt;
    logic [DIST_W-1:0]   r_cm_cnt;
    logic [DIST_W-1:0]   w_cm_next;

    logic                r_trig;
    logic [DIST_W-1:0]   r_dist_cm;
    logic                r_dist_valid;
    logic                r_timeout;

    logic                w_tick;
    logic                w_start_rise;
    logic                w_echo_rise;
    logic                w_echo_fall;
    logic                w_trig_done;
    logic                w_to_done;
    logic                w_hold_done;
    logic                w_sub_wrap;
    logic                w_valid_nxt;
    logic                w_timeout_nxt;

    us_tick_gen #(
        .DIV (c_us_div)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_state_chg),
        .tick  (w_tick)
    );

    // The start history resets high so a level held through reset is not
    // mistaken for a request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_d <= 1'b1;
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_start_d <= start;
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_start_rise = start & ~r_start_d;
    assign w_echo_rise  = r_echo_s2 & ~r_echo_d;
    assign w_echo_fall  = ~r_echo_s2 & r_echo_d;

    assign w_trig_done  = w_tick && (r_us_cnt == c_trig_last);
    assign w_to_done    = w_tick && (r_us_cnt == c_to_last);
    assign w_hold_done  = w_tick && (r_us_cnt == c_hold_last);
    assign w_sub_wrap   = w_tick && (r_sub_cnt == c_sub_last);

    // Includes this cycle's wrap so a fall coinciding with a cm boundary
    // reports the completed centimetre.
    always_comb begin
        w_cm_next = r_cm_cnt;
        if (w_sub_wrap && (r_cm_cnt != {DIST_W{1'b1}})) begin
            w_cm_next = r_cm_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (w_trig_done) begin
                    w_state_nxt = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (w_echo_rise) begin
                    w_state_nxt = ST_MEASURE;
                end else if (w_to_done) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HOLDOFF;
                end
            end
            ST_MEASURE: begin
                if (w_echo_fall) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLDOFF;
                end else if (w_to_done) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_us_cnt     <= '0;
            r_sub_cnt    <= '0;
            r_cm_cnt     <= '0;
            r_trig       <= 1'b0;
            r_dist_cm    <= '0;
            r_dist_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_trig       <= (w_state_nxt == ST_TRIG);
            r_dist_valid <= w_valid_nxt;
            r_timeout    <= w_timeout_nxt;

            if (w_state_chg) begin
                r_us_cnt <= '0;
            end else if (w_tick && (r_us_cnt != {c_us_w{1'b1}})) begin
                r_us_cnt <= r_us_cnt + 1'b1;
            end

            if (w_state_chg) begin
                r_sub_cnt <= '0;
                r_cm_cnt  <= '0;
            end else if ((r_state == ST_MEASURE) && w_tick) begin
                r_sub_cnt <= w_sub_wrap ? '0 : r_sub_cnt + 1'b1;
                r_cm_cnt  <= w_cm_next;
            end

            if (w_valid_nxt) begin
                r_dist_cm <= w_cm_next;
            end
        end
    end

    assign trig       = r_trig;
    assign busy       = (r_state != ST_IDLE);
    assign dist_cm    = r_dist_cm;
    assign dist_valid = r_dist_valid;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_echo_timer.sv
// ============================================================================
// Module   : tb_ultrasonic_echo_timer
// Brief    : Directed self-checking bench for ultrasonic_echo_timer at 4 MHz.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ultrasonic_echo_timer;

    localparam int CLK_HZ     = 4_000_000;
    localparam int TRIG_US    = 10;
    localparam int CM_US      = 58;
    localparam int TIMEOUT_US = 1500;
    localparam int HOLDOFF_US = 100;
    localparam int c_cpu      = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        echo  = 1'b0;
    logic        trig;
    logic        busy;
    logic [15:0] dist_cm;
    logic        dist_valid;
    logic        timeout;

    int n_checks    = 0;
    int n_errors    = 0;
    int n_valid     = 0;
    int n_timeout   = 0;
    int n_trig_rise = 0;
    int n_overlap   = 0;
    logic trig_prev = 1'b0;

    ultrasonic_echo_timer #(
        .CLK_HZ     (CLK_HZ),
        .TRIG_US    (TRIG_US),
        .CM_US      (CM_US),
        .TIMEOUT_US (TIMEOUT_US),
        .HOLDOFF_US (HOLDOFF_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dist_valid) n_valid++;
        if (timeout) n_timeout++;
        if (dist_valid && timeout) n_overlap++;
        if (trig && !trig_prev) n_trig_rise++;
        trig_prev = trig;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fire_trig(output int len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len = 0;
        while (trig && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic run_meas(input int echo_us, input bit spam, output int trig_len, output int lat);
        fire_trig(trig_len);
        repeat (100 * c_cpu) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < echo_us * c_cpu; i++) begin
            if (spam) start = ((i % 200) == 100);
            @(negedge clk);
        end
        start = 1'b0;
        echo  = 1'b0;
        lat   = 0;
        while (!dist_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle(input bit spam, output int n);
        n = 0;
        while (busy && n < 20000) begin
            if (spam) start = ((n % 50) == 25);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic meas_case(input string tag, input int echo_us, input int exp_cm, input bit spam);
        int len, lat, hold, v0, r0;
        v0 = n_valid;
        r0 = n_trig_rise;
        run_meas(echo_us, spam, len, lat);
        chk({tag, "_trig_len"}, len, TRIG_US * c_cpu);
        chk({tag, "_valid_lat"}, lat, 3);
        chk({tag, "_dist"}, dist_cm, exp_cm);
        wait_idle(spam, hold);
        chk({tag, "_holdoff"}, hold, HOLDOFF_US * c_cpu);
        chk({tag, "_valid_cnt"}, n_valid, v0 + 1);
        chk({tag, "_trig_cnt"}, n_trig_rise, r0 + 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int len, k, hold, v0, t0;

        repeat (4) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dist", dist_cm, 0);
        chk("rst_valid", dist_valid, 0);
        chk("rst_timeout", timeout, 0);

        // start already high when reset releases must not trigger
        start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("lvl_start_busy", busy, 0);
        chk("lvl_start_trig", n_trig_rise, 0);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of the trigger pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_trig_high", trig, 1);
        #2 reset = 1'b0;
        #1 chk("async_trig_drop", trig, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dist", dist_cm, 0);
        repeat (4) @(negedge clk);

        meas_case("e580", 580, 10, 1'b0);
        meas_case("e1159", 1159, 19, 1'b0);
        meas_case("e1160", 1160, 20, 1'b0);

        // echo never rises
        v0 = n_valid;
        t0 = n_timeout;
        fire_trig(len);
        chk("noecho_trig_len", len, TRIG_US * c_cpu);
        k = 0;
        while (!timeout && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("noecho_to_time", k, TIMEOUT_US * c_cpu);
        chk("noecho_busy", busy, 1);
        chk("noecho_dist", dist_cm, 20);
        wait_idle(1'b0, hold);
        chk("noecho_holdoff", hold, HOLDOFF_US * c_cpu);
        chk("noecho_to_cnt", n_timeout, t0 + 1);
        chk("noecho_valid_cnt", n_valid, v0);
        repeat (4) @(negedge clk);

        // echo stuck high
        v0 = n_valid;
        t0 = n_timeout;
        fire_trig(len);
        repeat (100 * c_cpu) @(negedge clk);
        echo = 1'b1;
        k = 0;
        while (!timeout && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("stuck_to_time", k, TIMEOUT_US * c_cpu + 3);
        chk("stuck_dist", dist_cm, 20);
        wait_idle(1'b0, hold);
        chk("stuck_holdoff", hold, HOLDOFF_US * c_cpu);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        chk("stuck_to_cnt", n_timeout, t0 + 1);
        chk("stuck_valid_cnt", n_valid, v0);
        chk("stuck_dist_hold", dist_cm, 20);

        // start edges while busy are dropped; the next one after idle works
        meas_case("spam", 580, 10, 1'b1);
        meas_case("after_spam", 1160, 20, 1'b0);

        chk("valid_timeout_overlap", n_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
